// File: rtl/register_file.sv
// Two-read, one-write register file with a load scoreboard that raises Stall on busy operands.
// Optional write-to-read bypass is enabled by defining the macro REGFILE_BYPASS_EN.
module register_file #(
   parameter int unsigned n    = 32,
   parameter int unsigned NREG = 32
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [4:0]   RA,
   input  logic [4:0]   RB,
   input  logic [4:0]   RW,
   input  logic [n-1:0] BusW,
   input  logic         RegWr,
   input  logic         LdIssue,
   input  logic [4:0]   LdReg,
   output logic [n-1:0] BusA,
   output logic [n-1:0] BusB,
   output logic         Stall
);

   localparam int unsigned AW = 5;

   logic [n-1:0]    regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic            wr_en;
   logic            byp_a;
   logic            byp_b;

   assign wr_en = RegWr && (RW != AW'(0));

   // Scoreboard update: clear on write-back, then set on load issue so a new load wins
   always_comb begin
      busy_nxt = busy;
      if (RegWr) begin
         busy_nxt[RW] = 1'b0;
      end
      if (LdIssue && (LdReg != AW'(0))) begin
         busy_nxt[LdReg] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (wr_en) begin
            regs[RW] <= BusW;
         end
         busy <= busy_nxt;
      end
   end

   // Bypass only for a live, non-R0 write outside reset
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      byp_a = !Reset && wr_en && (RA == RW);
      byp_b = !Reset && wr_en && (RB == RW);
`else
      byp_a = 1'b0;
      byp_b = 1'b0;
`endif
   end

   always_comb begin
      BusA = (RA == AW'(0)) ? '0 : regs[RA];
      BusB = (RB == AW'(0)) ? '0 : regs[RB];
      if (byp_a) begin
         BusA = BusW;
      end
      if (byp_b) begin
         BusB = BusW;
      end
      Stall = ((RA != AW'(0)) && busy[RA] && !byp_a) ||
              ((RB != AW'(0)) && busy[RB] && !byp_b);
   end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_file;

   logic        Clk;
   logic        Reset;
   logic [4:0]  RA;
   logic [4:0]  RB;
   logic [4:0]  RW;
   logic [31:0] BusW;
   logic        RegWr;
   logic        LdIssue;
   logic [4:0]  LdReg;
   logic [31:0] BusA;
   logic [31:0] BusB;
   logic        Stall;

   int checks   = 0;
   int failures = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   register_file #(.n(32), .NREG(32)) dut (
      .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW),
      .RegWr(RegWr), .LdIssue(LdIssue), .LdReg(LdReg),
      .BusA(BusA), .BusB(BusB), .Stall(Stall)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Reset = 1'b0; RegWr = 1'b0; LdIssue = 1'b0;
      RW = 5'd0; LdReg = 5'd0; BusW = 32'h0;
   endtask

   initial begin
      logic [31:0] sum;
      idle();
      RA = 5'd0; RB = 5'd0;
      Reset = 1'b1;
      tick();
      idle();
      RA = 5'd5; RB = 5'd31; #1;
      chk("rst_busa", BusA, 32'h0);
      chk("rst_busb", BusB, 32'h0);
      chk("rst_stall", 32'(Stall), 32'h0);

      // Write then reset with a concurrent write and load that must be ignored
      RegWr = 1'b1; RW = 5'd5; BusW = 32'hDEADBEEF;
      tick();
      idle(); RA = 5'd5; #1;
      chk("r5_write", BusA, 32'hDEADBEEF);
      Reset = 1'b1; RegWr = 1'b1; RW = 5'd6; BusW = 32'h1111;
      LdIssue = 1'b1; LdReg = 5'd6;
      tick();
      idle(); RA = 5'd5; RB = 5'd6; #1;
      chk("r5_after_rst", BusA, 32'h0);
      chk("r6_wr_ignored", BusB, 32'h0);
      chk("stall_after_rst", 32'(Stall), 32'h0);

      // R0 write discarded
      RegWr = 1'b1; RW = 5'd0; BusW = 32'h12345678; RA = 5'd0; #1;
      chk("r0_same_cycle", BusA, 32'h0);
      tick();
      idle(); #1;
      chk("r0_next", BusA, 32'h0);

      // RA==RB and ALU add
      RegWr = 1'b1; RW = 5'd7; BusW = 32'hA5A5A5A5;
      tick();
      RW = 5'd8; BusW = 32'h1;
      tick();
      idle(); RA = 5'd7; RB = 5'd7; #1;
      chk("r7_porta", BusA, 32'hA5A5A5A5);
      chk("r7_portb", BusB, 32'hA5A5A5A5);
      RB = 5'd8; #1;
      sum = BusA + BusB;
      chk("alu_add", sum, 32'hA5A5A5A6);

      // Same-cycle write/read of R9
      RegWr = 1'b1; RW = 5'd9; BusW = 32'h11;
      tick();
      RW = 5'd9; BusW = 32'h55; RA = 5'd9; RB = 5'd9; #1;
      chk("byp_a_r9", BusA, BYP ? 32'h55 : 32'h11);
      chk("byp_b_r9", BusB, BYP ? 32'h55 : 32'h11);
      tick();
      RW = 5'd10; BusW = 32'hAA; #1;
      chk("no_byp_other_reg", BusA, 32'h55);
      tick();
      idle(); #1;

      // Load to R4: stall until write-back
      LdIssue = 1'b1; LdReg = 5'd4; RA = 5'd4; RB = 5'd0; #1;
      chk("ld_issue_cycle", 32'(Stall), 32'h0);
      tick();
      idle(); #1;
      chk("ld_busy", 32'(Stall), 32'h1);
      tick();
      chk("ld_busy_hold", 32'(Stall), 32'h1);
      RegWr = 1'b1; RW = 5'd4; BusW = 32'h44; #1;
      chk("wb_stall", 32'(Stall), BYP ? 32'h0 : 32'h1);
      chk("wb_data", BusA, BYP ? 32'h44 : 32'h0);
      tick();
      idle(); #1;
      chk("wb_stall_next", 32'(Stall), 32'h0);
      chk("wb_data_next", BusA, 32'h44);

      // Set wins over clear on the same register
      LdIssue = 1'b1; LdReg = 5'd3; RegWr = 1'b1; RW = 5'd3; BusW = 32'h33;
      RA = 5'd0; RB = 5'd0;
      tick();
      idle(); RB = 5'd3; #1;
      chk("set_wins_stall", 32'(Stall), 32'h1);
      chk("set_wins_data", BusB, 32'h33);
      LdIssue = 1'b1; LdReg = 5'd3;
      tick();
      idle(); #1;
      chk("reissue_busy", 32'(Stall), 32'h1);

      // Reset mid-load, late write treated as ordinary
      Reset = 1'b1;
      tick();
      idle(); #1;
      chk("midload_rst_stall", 32'(Stall), 32'h0);
      RegWr = 1'b1; RW = 5'd3; BusW = 32'h77;
      tick();
      idle(); #1;
      chk("late_write_data", BusB, 32'h77);
      chk("late_write_stall", 32'(Stall), 32'h0);

      // LdReg=0 never marks R0 busy
      LdIssue = 1'b1; LdReg = 5'd0; RA = 5'd0; RB = 5'd0;
      tick();
      idle(); #1;
      chk("r0_never_busy", 32'(Stall), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter n, default 32, data word width; it SHALL match the downstream ALU BusA/BusB width.
REQ-002 Parameter NREG, default 32, register count; register addresses SHALL be 5 bits.
REQ-003 Clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 RA  input  5  read address, port A.
REQ-006 RB  input  5  read address, port B.
REQ-007 RW  input  5  write address.
REQ-008 BusW  input  n  write data (ALU or memory result).
REQ-009 RegWr  input  1  write enable.
REQ-010 LdIssue  input  1  a multi-cycle load targeting LdReg was issued this cycle.
REQ-011 LdReg  input  5  destination register of the issued load.
REQ-012 BusA  output  n  read data, port A; drives ALU BusA.
REQ-013 BusB  output  n  read data, port B; drives ALU BusB or the immediate mux.
REQ-014 Stall  output  1  a read operand is busy, and the issue stage SHALL hold.

Function
REQ-015 Reads SHALL be combinational: BusA = R[RA], BusB = R[RB], with zero-cycle latency.
REQ-016 When RegWr=1 and RW!=0, R[RW] SHALL take BusW at the rising edge of Clk.
REQ-017 R0 SHALL read as 0 at all times; a write to R0 SHALL be discarded.
REQ-018 Scoreboard: one busy bit per register; busy[0] SHALL be constant 0.
REQ-019 When LdIssue=1 and LdReg!=0, busy[LdReg] SHALL be set at the rising edge.
REQ-020 When RegWr=1, busy[RW] SHALL be cleared at the rising edge.
REQ-021 When set and clear hit the same register in one cycle, set SHALL win (a new load supersedes the old one).
REQ-022 Stall SHALL be combinational: (busy[RA] & RA!=0) | (busy[RB] & RB!=0), subject to REQ-029.
REQ-023 When RA==RB, both ports SHALL return identical data.
REQ-024 LdIssue to a register that is already busy SHALL leave the bit set and raise no error.

Reset
REQ-025 While Reset=1 at a rising edge, R1..R31 SHALL clear to 0 and all busy bits SHALL clear.
REQ-026 While Reset=1, a write or LdIssue in the same cycle SHALL be ignored.
REQ-027 After reset, BusA=0, BusB=0 and Stall=0 for any addresses.
REQ-028 When Reset is asserted mid-load, the pending busy state SHALL be discarded and the late write SHALL be accepted as an ordinary write.

Configuration
REQ-029 The macro REGFILE_BYPASS_EN SHALL control write-to-read bypass.
- Defined: when RegWr=1, RW!=0 and RA==RW (or RB==RW), the read port SHALL return the BusW of the current cycle, and that register's busy bit SHALL not contribute to Stall.
- Undefined: a read returns the pre-edge contents, and Stall reflects busy bits as stored.
- In both cases, R0 remains 0 and the bypass is suppressed while Reset=1.

Verification
REQ-030 Reset=1 for one edge after writing 0xDEADBEEF to R5 -> R5 reads 0 and Stall=0.
REQ-031 Write 0x12345678 to R0 with RegWr=1 -> BusA with RA=0 reads 0x00000000.
REQ-032 Write 0xA5A5A5A5 to R7, then read RA=7 and RB=7 -> both ports return 0xA5A5A5A5, and the value feeds the ALU ADD with R8=1 to give 0xA5A5A5A6.
REQ-033 Same-cycle write of 0x55 to R9 with RA=9 -> with the macro, BusA=0x55 in that cycle; without it, BusA shows the old value and 0x55 appears the next cycle.
REQ-034 LdIssue with LdReg=4, then RA=4 -> Stall=1 until the write of RegWr=1 to RW=4; the cycle after, Stall=0 (or in the same cycle with bypass).
REQ-035 Simultaneous LdIssue with LdReg=3 and RegWr with RW=3 -> busy[3] stays 1 and Stall=1 for RA=3 the next cycle.
